// File: rtl/dut_cmd_master.sv
// Command sequencer for the 8-entry 1-bit dut write/read interface: command FIFO -> in-order issue -> response FIFO.
// Optional head-of-line watchdog enabled by defining DUT_CMD_MASTER_WATCHDOG_EN.
module dut_cmd_master #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [2:0] cmd_addr,
  input  logic       cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [2:0] rsp_addr,
  output logic       rsp_data,
  output logic [2:0] write_address,
  output logic       write_data,
  output logic       write_en,
  input  logic       write_rdy,
  output logic [2:0] read_address,
  output logic       read_en,
  input  logic       read_data,
  input  logic       read_rdy,
  output logic       busy,
  output logic       err
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;

  state_t           state_q, state_d;
  logic [CAW-1:0]   cmdWr_q, cmdRd_q;
  logic [CAW:0]     cmdCnt_q, cmdCnt_d;
  logic [RAW-1:0]   rspWr_q, rspRd_q;
  logic [RAW:0]     rspCnt_q, rspCnt_d;
  logic             cmdOpMem   [CMD_DEPTH];
  logic [2:0]       cmdAddrMem [CMD_DEPTH];
  logic             cmdDataMem [CMD_DEPTH];
  logic [2:0]       rspAddrMem [RSP_DEPTH];
  logic             rspDataMem [RSP_DEPTH];

  logic       headValid, headOp, headData, cmdFull, rspFull;
  logic [2:0] headAddr;
  logic       cmdPush, cmdPop, rspPush, rspPop, dropHead;

  assign headValid = (cmdCnt_q != '0);
  assign headOp    = cmdOpMem[cmdRd_q];
  assign headAddr  = cmdAddrMem[cmdRd_q];
  assign headData  = cmdDataMem[cmdRd_q];
  assign cmdFull   = (cmdCnt_q == (CAW+1)'(CMD_DEPTH));
  assign rspFull   = (rspCnt_q == (RAW+1)'(RSP_DEPTH));

  // Ready comes from the registered count only, so a full FIFO never accepts even while popping.
  assign cmd_ready = !RST && !cmdFull;
  assign cmdPush   = cmd_valid && cmd_ready;

  assign write_en      = (state_q == ISSUE) && headValid && !headOp && write_rdy;
  assign read_en       = (state_q == ISSUE) && headValid && headOp && read_rdy && !rspFull;
  assign write_address = (headValid && !headOp) ? headAddr : 3'd0;
  assign write_data    = headValid && !headOp && headData;
  assign read_address  = (headValid && headOp) ? headAddr : 3'd0;

  assign rsp_valid = (rspCnt_q != '0);
  assign rsp_addr  = rsp_valid ? rspAddrMem[rspRd_q] : 3'd0;
  assign rsp_data  = rsp_valid && rspDataMem[rspRd_q];
  assign busy      = headValid;

  assign cmdPop  = write_en || read_en || dropHead;
  assign rspPush = read_en;
  assign rspPop  = rsp_valid && rsp_ready;

`ifdef DUT_CMD_MASTER_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q;
  logic           wdActive;

  assign wdActive = (state_q == ISSUE) || (state_q == STALL);
  assign dropHead = wdActive && !write_en && !read_en && (wd_q == WDW'(TIMEOUT));
  assign err      = err_q;

  always_comb begin
    wd_d = wd_q;
    if (write_en || read_en || dropHead) wd_d = '0;
    else if (wdActive)                   wd_d = wd_q + WDW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (dropHead) err_q <= 1'b1;
    end
  end
`else
  assign dropHead = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    cmdCnt_d = cmdCnt_q;
    if (cmdPush && !cmdPop)      cmdCnt_d = cmdCnt_q + (CAW+1)'(1);
    else if (!cmdPush && cmdPop) cmdCnt_d = cmdCnt_q - (CAW+1)'(1);
    rspCnt_d = rspCnt_q;
    if (rspPush && !rspPop)      rspCnt_d = rspCnt_q + (RAW+1)'(1);
    else if (!rspPush && rspPop) rspCnt_d = rspCnt_q - (RAW+1)'(1);
  end

  // Next state looks at the next count so a push into an empty FIFO can issue one cycle later.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmdCnt_d != '0) state_d = ISSUE;
      ISSUE: begin
        if (cmdCnt_d == '0)                     state_d = IDLE;
        else if (!cmdPop && headOp && rspFull)  state_d = STALL;
      end
      STALL: begin
        if (cmdCnt_d == '0)  state_d = IDLE;
        else if (!rspFull)   state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cmdWr_q  <= '0;
      cmdRd_q  <= '0;
      cmdCnt_q <= '0;
      rspWr_q  <= '0;
      rspRd_q  <= '0;
      rspCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cmdCnt_q <= cmdCnt_d;
      rspCnt_q <= rspCnt_d;
      if (cmdPush) cmdWr_q <= cmdWr_q + CAW'(1);
      if (cmdPop)  cmdRd_q <= cmdRd_q + CAW'(1);
      if (rspPush) rspWr_q <= rspWr_q + RAW'(1);
      if (rspPop)  rspRd_q <= rspRd_q + RAW'(1);
    end
  end

  // Storage needs no reset; the occupancy counters decide what is valid.
  always_ff @(posedge CLK) begin
    if (cmdPush) begin
      cmdOpMem[cmdWr_q]   <= cmd_op;
      cmdAddrMem[cmdWr_q] <= cmd_addr;
      cmdDataMem[cmdWr_q] <= cmd_data;
    end
    if (rspPush) begin
      rspAddrMem[rspWr_q] <= read_address;
      rspDataMem[rspWr_q] <= read_data;
    end
  end
endmodule

// File: tb/tb_dut_cmd_master.sv
// Self-checking bench for dut_cmd_master: vector table, directed corner cases and a randomized scoreboard run.
// Watchdog test is compiled only when DUT_CMD_MASTER_WATCHDOG_EN is defined.
module tb_dut_cmd_master;
`ifdef DUT_CMD_MASTER_WATCHDOG_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 255;
`endif
  localparam int CMD_DEPTH = 4;
  localparam int RSP_DEPTH = 4;

  logic       CLK, RST;
  logic       cmd_valid, cmd_ready, cmd_op, cmd_data;
  logic [2:0] cmd_addr;
  logic       rsp_valid, rsp_ready, rsp_data;
  logic [2:0] rsp_addr;
  logic [2:0] write_address, read_address;
  logic       write_data, write_en, write_rdy;
  logic       read_en, read_data, read_rdy;
  logic       busy, err;

  int checks = 0;
  int errors = 0;

  bit devMem [8];
  bit refMem [8];
  bit goldMem [8];

  typedef struct {
    logic op;
    logic [2:0] addr;
    logic data;
  } cmd_t;

  typedef struct {
    logic [2:0] addr;
    logic data;
  } rsp_t;

  cmd_t cmdQ[$];
  rsp_t expRsp[$];
  int   outstanding;

  typedef struct {
    logic cv; logic op; logic [2:0] addr; logic data;
    logic wr; logic rr; logic rspr;
    logic expWe; logic expRe; logic expRv; logic [2:0] expRa; logic expRd;
    logic expCr; logic expBusy;
  } vec_t;
  vec_t vecs [5];

  dut_cmd_master #(.CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH), .TIMEOUT(TB_TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .write_address(write_address), .write_data(write_data), .write_en(write_en),
    .write_rdy(write_rdy), .read_address(read_address), .read_en(read_en),
    .read_data(read_data), .read_rdy(read_rdy), .busy(busy), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Bench-side model of the 8x1 dut memory: combinational read, write on the clock edge.
  assign read_data = devMem[read_address];
  always @(posedge CLK) if (write_en) devMem[write_address] <= write_data;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic cv, input logic op, input logic [2:0] addr, input logic data,
                               input logic wr, input logic rr, input logic rspr);
    cmd_valid = cv; cmd_op = op; cmd_addr = addr; cmd_data = data;
    write_rdy = wr; read_rdy = rr; rsp_ready = rspr;
  endtask

  // One randomized (or draining) cycle checked against the transaction-level scoreboard.
  task automatic randomCycle(input bit drain);
    logic cv, op, data, wr, rr, rspr;
    logic [2:0] addr;
    bit modelReady;
    cmd_t c;
    rsp_t r;
    tick();
    cv   = drain ? 1'b0 : 1'($urandom_range(0, 1));
    op   = 1'($urandom_range(0, 1));
    addr = 3'($urandom_range(0, 7));
    data = 1'($urandom_range(0, 1));
`ifdef DUT_CMD_MASTER_WATCHDOG_EN
    wr   = 1'b1;
    rr   = 1'b1;
    rspr = drain ? 1'b1 : 1'($urandom_range(0, 7) != 0);
`else
    wr   = drain ? 1'b1 : 1'($urandom_range(0, 3) != 0);
    rr   = drain ? 1'b1 : 1'($urandom_range(0, 3) != 0);
    rspr = drain ? 1'b1 : 1'($urandom_range(0, 2) != 0);
`endif
    applyStimulus(cv, op, addr, data, wr, rr, rspr);
    #3;
    modelReady = (cmdQ.size() < CMD_DEPTH);
    checkOutput("rnd_cmd_ready", cmd_ready, modelReady);
    checkOutput("rnd_busy", busy, cmdQ.size() != 0);
    checkOutput("rnd_rsp_valid", rsp_valid, outstanding > 0);
    checkOutput("rnd_err", err, 0);
    if (write_en && read_en) checkOutput("rnd_two_en", 1, 0);
    if (write_en) begin
      checkOutput("rnd_we_rdy", write_rdy, 1);
      if (cmdQ.size() == 0) checkOutput("rnd_we_empty", 1, 0);
      else begin
        c = cmdQ.pop_front();
        checkOutput("rnd_we_op", 0, c.op);
        checkOutput("rnd_we_addr", write_address, c.addr);
        checkOutput("rnd_we_data", write_data, c.data);
      end
    end else if (read_en) begin
      checkOutput("rnd_re_rdy", read_rdy, 1);
      checkOutput("rnd_re_rspfull", outstanding < RSP_DEPTH, 1);
      if (cmdQ.size() == 0) checkOutput("rnd_re_empty", 1, 0);
      else begin
        c = cmdQ.pop_front();
        checkOutput("rnd_re_op", 1, c.op);
        checkOutput("rnd_re_addr", read_address, c.addr);
      end
      outstanding++;
    end
    if (rsp_valid && rsp_ready) begin
      if (expRsp.size() == 0) checkOutput("rnd_rsp_unexpected", 1, 0);
      else begin
        r = expRsp.pop_front();
        checkOutput("rnd_rsp_addr", rsp_addr, r.addr);
        checkOutput("rnd_rsp_data", rsp_data, r.data);
      end
      outstanding--;
    end
    if (cv && modelReady) begin
      c.op = op; c.addr = addr; c.data = data;
      cmdQ.push_back(c);
      if (!op) goldMem[addr] = data;
      else begin
        r.addr = addr; r.data = goldMem[addr];
        expRsp.push_back(r);
      end
    end
  endtask

  initial begin
    int enCount, accepted, respCount;
    rsp_t got [$];
    RST = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset_cmd_ready", cmd_ready, 0);
    checkOutput("reset_write_en", write_en, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    #3;
    checkOutput("idle_cmd_ready", cmd_ready, 1);
    checkOutput("idle_rsp_valid", rsp_valid, 0);
    checkOutput("idle_write_en", write_en, 0);
    checkOutput("idle_read_en", read_en, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_err", err, 0);

    // Write 5<=1 then read 5: write_en, read_en, then the response one cycle later.
    vecs[0] = '{1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      tick();
      applyStimulus(vecs[i].cv, vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].wr, vecs[i].rr, vecs[i].rspr);
      #3;
      checkOutput($sformatf("vec%0d_write_en", i), write_en, vecs[i].expWe);
      checkOutput($sformatf("vec%0d_read_en", i), read_en, vecs[i].expRe);
      checkOutput($sformatf("vec%0d_rsp_valid", i), rsp_valid, vecs[i].expRv);
      checkOutput($sformatf("vec%0d_rsp_addr", i), rsp_addr, vecs[i].expRa);
      checkOutput($sformatf("vec%0d_rsp_data", i), rsp_data, vecs[i].expRd);
      checkOutput($sformatf("vec%0d_cmd_ready", i), cmd_ready, vecs[i].expCr);
      checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].expBusy);
      if (i == 1) checkOutput("vec1_write_address", write_address, 5);
      if (i == 2) checkOutput("vec2_read_address", read_address, 5);
    end
    refMem[5] = 1'b1;

    // write_rdy held low with four writes queued; a fifth is refused.
    for (int i = 0; i < 4; i++) begin
      tick();
      applyStimulus(1, 0, 3'(i + 1), 1'(i % 2), 0, 1, 1);
      #3;
      checkOutput($sformatf("fill%0d_cmd_ready", i), cmd_ready, 1);
      refMem[i + 1] = 1'(i % 2);
    end
    enCount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      applyStimulus(1, 0, 3'd7, 1, 0, 1, 1);
      #3;
      if (write_en) enCount++;
      if (i == 9) checkOutput("full_cmd_ready", cmd_ready, 0);
    end
    checkOutput("stall_write_en_count", enCount, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      applyStimulus(0, 0, 0, 0, 1, 1, 1);
      #3;
      checkOutput($sformatf("drain%0d_write_en", i), write_en, 1);
      checkOutput($sformatf("drain%0d_write_address", i), write_address, i + 1);
      checkOutput($sformatf("drain%0d_write_data", i), write_data, i % 2);
    end
    tick();
    #3;
    checkOutput("after_drain_write_en", write_en, 0);
    checkOutput("after_drain_busy", busy, 0);

    // Six reads against a blocked consumer: only RSP_DEPTH may issue.
    enCount = 0;
    accepted = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      applyStimulus(accepted < 6, 1, 3'(accepted), 0, 1, 1, 0);
      #3;
      if (read_en) enCount++;
      if (cmd_valid && cmd_ready) accepted++;
    end
    checkOutput("rsp_block_read_count", enCount, RSP_DEPTH);
    checkOutput("rsp_block_read_en", read_en, 0);
    checkOutput("rsp_block_accepted", accepted, 6);
    checkOutput("rsp_block_busy", busy, 1);
    enCount = 0;
    respCount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      applyStimulus(0, 0, 0, 0, 1, 1, 1);
      #3;
      if (read_en) enCount++;
      if (rsp_valid && rsp_ready) begin
        if (respCount < 6) begin
          checkOutput($sformatf("order%0d_rsp_addr", respCount), rsp_addr, respCount);
          checkOutput($sformatf("order%0d_rsp_data", respCount), rsp_data, refMem[respCount]);
        end
        respCount++;
      end
    end
    checkOutput("release_read_count", enCount, 2);
    checkOutput("release_resp_count", respCount, 6);

    // Reset mid-burst: one response pending and two writes queued.
    tick();
    applyStimulus(1, 1, 3'd2, 0, 0, 1, 0);
    tick();
    applyStimulus(1, 0, 3'd6, 1, 0, 1, 0);
    tick();
    applyStimulus(1, 0, 3'd7, 1, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    #3;
    checkOutput("pre_reset_busy", busy, 1);
    checkOutput("pre_reset_rsp_valid", rsp_valid, 1);
    RST = 1'b1;
    write_rdy = 1'b1;
    #1;
    checkOutput("async_reset_cmd_ready", cmd_ready, 0);
    checkOutput("async_reset_busy", busy, 0);
    checkOutput("async_reset_rsp_valid", rsp_valid, 0);
    checkOutput("async_reset_rsp_addr", rsp_addr, 0);
    checkOutput("async_reset_write_en", write_en, 0);
    checkOutput("async_reset_write_address", write_address, 0);
    checkOutput("async_reset_read_en", read_en, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    rsp_ready = 1'b1;
    #3;
    checkOutput("post_reset_cmd_ready", cmd_ready, 1);
    checkOutput("post_reset_busy", busy, 0);
    checkOutput("post_reset_rsp_valid", rsp_valid, 0);
    enCount = 0;
    for (int i = 0; i < 4; i++) begin
      if (write_en || read_en || rsp_valid) enCount++;
      tick();
      #3;
    end
    checkOutput("post_reset_activity", enCount, 0);

    // Randomized traffic against the scoreboard, then a bounded drain.
    for (int a = 0; a < 8; a++) goldMem[a] = devMem[a];
    outstanding = 0;
    for (int i = 0; i < 2000; i++) randomCycle(1'b0);
    for (int i = 0; i < 200 && (cmdQ.size() != 0 || outstanding != 0); i++) randomCycle(1'b1);
    checkOutput("drain_cmd_queue", cmdQ.size(), 0);
    checkOutput("drain_outstanding", outstanding, 0);
    checkOutput("drain_expected_rsp", expRsp.size(), 0);

`ifdef DUT_CMD_MASTER_WATCHDOG_EN
    // A read stuck on read_rdy=0 is dropped after the watchdog limit.
    enCount = 0;
    accepted = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      applyStimulus(i == 0, 1, 3'd3, 0, 1, 0, 1);
      #3;
      if (read_en || rsp_valid) enCount++;
      if (busy) accepted++;
      if (i > 0 && !busy) break;
    end
    checkOutput("wd_busy_cycles", accepted, TB_TIMEOUT + 1);
    checkOutput("wd_no_access", enCount, 0);
    checkOutput("wd_err", err, 1);
    checkOutput("wd_busy", busy, 0);
    tick();
    applyStimulus(1, 0, 3'd6, 1, 1, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 1, 1);
    #3;
    checkOutput("wd_next_write_en", write_en, 1);
    checkOutput("wd_next_write_address", write_address, 6);
    checkOutput("wd_err_sticky", err, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dut_cmd_master.md
Name: dut_cmd_master

Overview:
- Upstream command sequencer that drives the 8-entry 1-bit `dut` write/read method interface.
- Accepts write/read commands from a bench or controller on a valid/ready stream and buffers them in a command FIFO.
- Issues commands to `dut` in order, obeying the EN-only-when-RDY method rule.
- Returns read results on a valid/ready response stream through a response FIFO.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of 2, >=2).
- RSP_DEPTH, 4, response FIFO entries (power of 2, >=2).
- TIMEOUT, 255, watchdog limit in cycles (used only with WATCHDOG_EN).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command FIFO not full.
- cmd_op  input  1  0 = write, 1 = read.
- cmd_addr  input  3  target address.
- cmd_data  input  1  write data (ignored for reads).
- rsp_valid  output  1  response FIFO not empty.
- rsp_ready  input  1  consumer accepts response.
- rsp_addr  output  3  address of the returned read.
- rsp_data  output  1  read data.
- write_address  output  3  to dut.
- write_data  output  1  to dut.
- write_en  output  1  to dut.
- write_rdy  input  1  from dut.
- read_address  output  3  to dut.
- read_en  output  1  to dut.
- read_data  input  1  from dut; valid in the same cycle as read_en.
- read_rdy  input  1  from dut.
- busy  output  1  command FIFO non-empty.
- err  output  1  sticky watchdog error (tied 0 without WATCHDOG_EN).

Behaviour:
- Reset (async, RST=1): both FIFOs emptied, FSM to IDLE, watchdog counter 0, err 0.
  - All outputs 0 except cmd_ready, which is 0 while RST=1 and 1 in the first cycle after release.
  - Commands and responses in flight are discarded; no EN is asserted during reset.
- Command push: cmd_valid & cmd_ready stores {op, addr, data}.
  - cmd_ready = !cmd_full, registered-count based, so there is no push-through when full even if a pop occurs the same cycle.
- FSM states:
  - IDLE: command FIFO empty. Goes to ISSUE when count becomes non-zero.
  - ISSUE: head valid. Goes to STALL when the head is a read and the response FIFO is full. Goes to IDLE when the last entry pops.
  - STALL: goes to ISSUE when the response FIFO is not full.
- write_address/write_data = head addr/data whenever the head is a write; otherwise 0.
- read_address = head addr whenever the head is a read; otherwise 0.
- write_en = (state==ISSUE) & head_op==0 & write_rdy. Combinational, never asserted while write_rdy=0.
- read_en = (state==ISSUE) & head_op==1 & read_rdy & !rsp_full. Combinational.
- Any asserted EN pops the command FIFO that cycle. At most one dut transaction per cycle; strictly in order.
- Read capture: in the read_en cycle, {read_address, read_data} is pushed to the response FIFO; rsp_valid rises the next cycle.
- Latency:
  - Command pushed into an empty FIFO at cycle N: earliest EN at N+1.
  - Read issued at N: rsp_valid at N+1.
- Response FIFO: pop on rsp_valid & rsp_ready. A push and a pop in the same cycle are both permitted (occupancy unchanged). rsp_full blocks read_en regardless of rsp_ready.
- Pointer wrap-around: modulo depth; occupancy counters sized log2(DEPTH)+1.
- busy = (cmd count != 0).

Optional Feature:
- Macro: DUT_CMD_MASTER_WATCHDOG_EN.
- Enabled:
  - A counter increments each cycle the FSM is in ISSUE or STALL without an EN, and clears on any EN.
  - When it reaches TIMEOUT, the head command is dropped (popped, no dut access, no response), err is set sticky until reset, and the counter clears.
- Disabled: no counter logic; err is constant 0; the head waits indefinitely.

Test Plan:
- Reset then idle -> cmd_ready=1, rsp_valid=0, write_en=0, read_en=0, busy=0, err=0.
- Write addr 5 data 1 with write_rdy=1, then read addr 5 -> write_en one cycle with write_address=5, write_data=1. Next, read_en one cycle. Next cycle: rsp_valid=1, rsp_addr=5, rsp_data=1.
- write_rdy held 0 for 10 cycles with 4 writes queued -> write_en stays 0, cmd_ready=0. A 5th cmd_valid is not accepted. Release write_rdy -> 4 consecutive write_en cycles, in order.
- 6 reads (addr 0..5) with rsp_ready=0 -> exactly 4 read_en, then FSM in STALL with read_en=0. Set rsp_ready=1 -> remaining 2 issue; all 6 responses arrive in address order 0..5.
- Assert RST mid-burst (2 commands queued, 1 response pending) -> all outputs cleared asynchronously; after release busy=0, rsp_valid=0, no EN.
- With DUT_CMD_MASTER_WATCHDOG_EN, TIMEOUT=8, read_rdy=0, one read queued -> the read is dropped after 8 stalled cycles, err=1, busy=0. The next write still issues normally.
